// File: rtl/bsg_flow_convert_credit_pkg.sv
// Shared helpers for the ready/valid to credit flow converter:
// counter sizing and parameter legality.
package bsg_flow_convert_credit_pkg;

  // Bit width needed to hold values 0..n-1, never less than 1.
  function automatic int safe_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r == 0) r = 1;
    return r;
  endfunction

  function automatic bit params_legal(input int width, input int max_credits,
                                      input int decimation);
    return (width >= 1) && (max_credits >= 1) && (decimation >= 1)
        && ((max_credits % decimation) == 0);
  endfunction

endpackage

// File: rtl/bsg_flow_credit_counter.sv
// Single-channel credit counter: gates upstream ready on available credit,
// saturates on excess credit return and records it in a sticky overflow flag.
module bsg_flow_credit_counter
  import bsg_flow_convert_credit_pkg::*;
#(
  parameter int max_credits_p = 8,
  parameter int decimation_p  = 1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic v_i,
  input  logic credit_i,
  output logic ready_o,
  output logic v_o,
  output logic overflow_o
);

  localparam int cnt_width_lp = safe_clog2(max_credits_p + 1);

  logic [cnt_width_lp-1:0] cnt_r;
  logic                    overflow_r;
  logic                    send;
  logic [31:0]             cnt_next;
  logic                    too_many;

  // Ready comes from the registered count only; reset masks all outputs.
  assign ready_o    = ~reset_i & (cnt_r != '0);
  assign send       = v_i & ready_o;
  assign v_o        = send;
  assign overflow_o = ~reset_i & overflow_r;

  always_comb begin
    cnt_next = 32'(cnt_r) - 32'(send) + (credit_i ? 32'(decimation_p) : 32'd0);
    too_many = (cnt_next > 32'(max_credits_p));
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_r      <= cnt_width_lp'(max_credits_p);
      overflow_r <= 1'b0;
    end else if (too_many) begin
      cnt_r      <= cnt_width_lp'(max_credits_p);
      overflow_r <= 1'b1;
    end else begin
      cnt_r      <= cnt_width_lp'(cnt_next);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i && too_many && !overflow_r)
      $warning("bsg_flow_credit_counter: credit return exceeded max_credits_p");
  end

endmodule

// File: rtl/bsg_flow_convert_credit.sv
// Converts per-channel ready/valid handshakes into credit-based valids,
// one independent credit counter per channel.
module bsg_flow_convert_credit
  import bsg_flow_convert_credit_pkg::*;
#(
  parameter int width_p       = 1,
  parameter int max_credits_p = 8,
  parameter int decimation_p  = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] v_i,
  output logic [width_p-1:0] ready_o,
  output logic [width_p-1:0] v_o,
  input  logic [width_p-1:0] credit_i,
  output logic [width_p-1:0] overflow_o
);

  if (!params_legal(width_p, max_credits_p, decimation_p)) begin : g_bad_params
    $error("bsg_flow_convert_credit: illegal width_p/max_credits_p/decimation_p");
  end

  for (genvar k = 0; k < width_p; k++) begin : g_ch
    bsg_flow_credit_counter #(
      .max_credits_p(max_credits_p),
      .decimation_p (decimation_p)
    ) u_cnt (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .v_i       (v_i[k]),
      .credit_i  (credit_i[k]),
      .ready_o   (ready_o[k]),
      .v_o       (v_o[k]),
      .overflow_o(overflow_o[k])
    );
  end

endmodule

// File: tb/tb_bsg_flow_convert_credit.sv
// Scoreboard bench: two converter configurations driven together against a
// downstream-buffer occupancy model.
module tb_bsg_flow_convert_credit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] v_a = '0, credit_a = '0;
  logic [1:0] ready_a, vo_a, ovf_a;
  logic [0:0] v_b = '0, credit_b = '0;
  logic [0:0] ready_b, vo_b, ovf_b;

  always #5 clk = ~clk;

  bsg_flow_convert_credit #(.width_p(2), .max_credits_p(4), .decimation_p(1)) dut_a (
    .clk_i(clk), .reset_i(reset), .v_i(v_a), .ready_o(ready_a), .v_o(vo_a),
    .credit_i(credit_a), .overflow_o(ovf_a));

  bsg_flow_convert_credit #(.width_p(1), .max_credits_p(8), .decimation_p(4)) dut_b (
    .clk_i(clk), .reset_i(reset), .v_i(v_b), .ready_o(ready_b), .v_o(vo_b),
    .credit_i(credit_b), .overflow_o(ovf_b));

  typedef struct packed {
    logic [1:0] ra, va, oa;
    logic       rb, vb, ob;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model state: items sitting downstream whose credit has not come back.
  int infl_a0 = 0, infl_a1 = 0, infl_b = 0;
  bit ovf_a0 = 0, ovf_a1 = 0, ovf_mb = 0;

  task automatic model_ch(input int maxc, input int dec, input bit rst, input bit v,
                          input bit c, inout int infl, inout bit ovf,
                          output bit rdy, output bit vo, output bit ov);
    if (rst) begin
      rdy = 0; vo = 0; ov = 0; infl = 0; ovf = 0;
    end else begin
      rdy  = (maxc - infl) > 0;
      vo   = v && rdy;
      ov   = ovf;
      infl = infl + (vo ? 1 : 0) - (c ? dec : 0);
      if (infl < 0) begin
        infl = 0;
        ovf  = 1;
      end
    end
  endtask

  task automatic step(input logic [1:0] va_in, input logic [1:0] ca_in,
                      input logic vb_in, input logic cb_in, input logic rst);
    exp_t e;
    bit r, v, o;
    reset    = rst;
    v_a      = va_in;
    credit_a = ca_in;
    v_b      = vb_in;
    credit_b = cb_in;
    model_ch(4, 1, rst, va_in[0], ca_in[0], infl_a0, ovf_a0, r, v, o);
    e.ra[0] = r; e.va[0] = v; e.oa[0] = o;
    model_ch(4, 1, rst, va_in[1], ca_in[1], infl_a1, ovf_a1, r, v, o);
    e.ra[1] = r; e.va[1] = v; e.oa[1] = o;
    model_ch(8, 4, rst, vb_in, cb_in, infl_b, ovf_mb, r, v, o);
    e.rb = r; e.vb = v; e.ob = o;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [1:0] act, input logic [1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("ready_a", ready_a, e.ra);
      check("v_o_a", vo_a, e.va);
      check("overflow_a", ovf_a, e.oa);
      check("ready_b", {1'b0, ready_b}, {1'b0, e.rb});
      check("v_o_b", {1'b0, vo_b}, {1'b0, e.vb});
      check("overflow_b", {1'b0, ovf_b}, {1'b0, e.ob});
    end
  end

  initial begin
    logic [1:0] ca;
    logic       cb;
    @(posedge clk);
    #1;
    repeat (2) step(2'b00, 2'b00, 0, 0, 1);

    // Channel 0 drains its 4 credits; channel 1 stays idle and ready.
    repeat (6) step(2'b01, 2'b00, 0, 0, 0);
    // Empty channel: returned credit usable only on the following cycle.
    step(2'b01, 2'b01, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0);
    step(2'b01, 2'b00, 0, 0, 0);

    // Send and credit return every cycle keeps the count full.
    step(2'b00, 2'b00, 0, 0, 1);
    repeat (20) step(2'b01, 2'b01, 0, 0, 0);

    // Leave one credit on channel 0, then reset with a credit in flight.
    repeat (3) step(2'b01, 2'b00, 0, 0, 0);
    repeat (2) step(2'b01, 2'b01, 1, 1, 1);
    repeat (5) step(2'b01, 2'b00, 0, 0, 0);

    // Decimated credits: 8 sends, 2 returns, an excess return, 8 more sends.
    repeat (9) step(2'b00, 2'b00, 1, 0, 0);
    repeat (2) step(2'b00, 2'b00, 0, 1, 0);
    step(2'b00, 2'b00, 0, 1, 0);
    repeat (9) step(2'b00, 2'b00, 1, 0, 0);
    step(2'b00, 2'b00, 0, 0, 1);

    // Random traffic; the downstream buffer only returns credits it owes.
    for (int i = 0; i < 400; i++) begin
      ca[0] = (infl_a0 > 0) && ($urandom_range(0, 2) == 0);
      ca[1] = (infl_a1 > 0) && ($urandom_range(0, 2) == 0);
      cb    = (infl_b >= 4) && ($urandom_range(0, 3) == 0);
      step(2'($urandom_range(0, 3)), ca, 1'($urandom_range(0, 1)), cb, 0);
    end
    for (int i = 0; i < 12; i++) begin
      ca[0] = infl_a0 > 0;
      ca[1] = infl_a1 > 0;
      cb    = infl_b >= 4;
      step(2'b00, ca, 0, cb, 0);
    end
    repeat (2) step(2'b00, 2'b00, 0, 0, 0);

    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bsg_flow_convert_credit.md
BSG_FLOW_CONVERT_CREDIT -- requirements
Module: bsg_flow_convert_credit

Interface
REQ-001 Parameter width_p, default 1: number of independent flow-control channels; legal range >= 1.
REQ-002 Parameter max_credits_p, default 8: credits each channel holds after reset, equal to the downstream buffer depth; legal range >= 1.
REQ-003 Parameter decimation_p, default 1: credits returned by one credit_i pulse; legal range >= 1; max_credits_p SHALL be an integer multiple of decimation_p.
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  reset; synchronous and active-high.
REQ-006 v_i  input  width_p  per-channel upstream valid (ready/valid side).
REQ-007 ready_o  output  width_p  per-channel upstream ready (ready-and: a transfer occurs when v_i & ready_o).
REQ-008 v_o  output  width_p  per-channel downstream valid (credit side); each asserted bit consumes one credit.
REQ-009 credit_i  input  width_p  per-channel credit return; each asserted bit adds decimation_p credits.
REQ-010 overflow_o  output  width_p  per-channel sticky error: credit return exceeded max_credits_p.

Function
REQ-011 Each channel SHALL hold a credit counter cnt[k], width clog2(max_credits_p+1) bits.
REQ-012 ready_o[k] SHALL be (cnt[k] != 0) and SHALL depend only on registered state, never combinationally on v_i or credit_i.
REQ-013 v_o[k] SHALL equal v_i[k] & ready_o[k] in the same cycle (zero latency); no data is buffered.
REQ-014 Next count SHALL be cnt[k] - send[k] + (credit_i[k] ? decimation_p : 0), where send[k] = v_o[k].
REQ-015 Simultaneous send and credit return in one cycle SHALL apply both (net +decimation_p-1).
REQ-016 Empty (cnt==0) with credit_i asserted: ready_o stays 0 that cycle; the credit becomes usable in the next cycle.
REQ-017 If the computed next count exceeds max_credits_p: cnt SHALL saturate at max_credits_p and overflow_o[k] SHALL set and remain set until reset.
REQ-018 Counter underflow SHALL be impossible by construction (send requires cnt != 0).
REQ-019 Channels SHALL be fully independent; activity on channel j never affects channel k.

Reset
REQ-020 While reset_i is high: cnt[k] SHALL load max_credits_p, overflow_o SHALL clear to 0, and ready_o and v_o SHALL be forced to 0.
REQ-021 credit_i asserted during reset SHALL be ignored.
REQ-022 Reset asserted mid-operation SHALL discard outstanding credit accounting; both link ends are reset together at system level.
REQ-023 In the first cycle after reset deasserts: ready_o = all ones, cnt = max_credits_p.

Structure
REQ-024 The shared package SHALL hold the counter-width helper (safe clog2 of max_credits_p+1) and the parameter-legality checks (REQ-003).
REQ-025 One sub-module, bsg_flow_credit_counter (single channel: counter, saturation, sticky overflow), SHALL be instantiated width_p times via generate.
REQ-026 Elaboration SHALL fail on illegal parameters; simulation SHALL assert on any overflow_o rising edge.

Verification
REQ-027 width_p=2, max_credits_p=4, decimation_p=1; reset, hold v_i=2'b01, no credit -> v_o[0] high for exactly 4 cycles, then ready_o[0]=0; channel 1 keeps ready_o[1]=1 and v_o[1]=0.
REQ-028 Same config with cnt[0]=0: pulse credit_i[0] for one cycle -> ready_o[0]=0 that cycle, 1 the next, and one transfer is accepted.
REQ-029 Same config: v_i[0]=1 and credit_i[0]=1 every cycle from reset for 20 cycles -> v_o[0]=1 every cycle, cnt stays 4, overflow_o=0.
REQ-030 max_credits_p=8, decimation_p=4: send 8, then return 2 credit pulses -> cnt=8 and 8 further sends are accepted; a third pulse at cnt=8 -> overflow_o[0]=1 and cnt stays 8.
REQ-031 Assert reset_i mid-stream with cnt[0]=1 and credit_i[0]=1 -> during reset ready_o=0, v_o=0; after reset cnt=max_credits_p and overflow_o=0.
REQ-032 Random v_i/credit_i per channel against a scoreboard model of the downstream buffer -> no transfer issued without a credit, no overflow, and every credit eventually consumed.
